// File: rtl/chip_checker_pkg.sv
// Shared types and helpers for the chip vector checker.
package chip_checker_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_DRIVE,
    ST_SETTLE,
    ST_SAMPLE,
    ST_DONE
  } state_t;

  localparam logic [15:0] ERR_MAX = 16'hFFFF;

  // Increment that sticks at ERR_MAX instead of wrapping.
  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == ERR_MAX) ? v : v + 16'd1;
  endfunction

endpackage

// File: rtl/chip_vector_ram.sv
// Vector store: one entry per test vector holding {stim, exp, mask}.
// Synchronous write, combinational read, no reset on the contents.
module chip_vector_ram
  import chip_checker_pkg::*;
#(
  parameter int NUM_OUT = 8,
  parameter int NUM_IN  = 8,
  parameter int DEPTH   = 16,
  localparam int AW     = $clog2(DEPTH)
) (
  input  logic               clk_clk,
  input  logic               we,
  input  logic [AW-1:0]      waddr,
  input  logic [NUM_OUT-1:0] wstim,
  input  logic [NUM_IN-1:0]  wexp,
  input  logic [NUM_IN-1:0]  wmask,
  input  logic [AW-1:0]      raddr,
  output logic [NUM_OUT-1:0] rstim,
  output logic [NUM_IN-1:0]  rexp,
  output logic [NUM_IN-1:0]  rmask
);

  localparam int W = NUM_OUT + 2 * NUM_IN;

  logic [W-1:0] mem_q [DEPTH];

  // Write port; contents are deliberately left unreset.
  always_ff @(posedge clk_clk) begin
    if (we) mem_q[waddr] <= {wstim, wexp, wmask};
  end

  assign {rstim, rexp, rmask} = mem_q[raddr];

endmodule

// File: rtl/chip_vector_checker.sv
// Vector sequencer: drives stored stimulus onto the socket, waits a settle
// time, compares the synchronized response and accumulates results.
module chip_vector_checker
  import chip_checker_pkg::*;
#(
  parameter int NUM_OUT       = 8,
  parameter int NUM_IN        = 8,
  parameter int DEPTH         = 16,
  parameter int SETTLE_CYCLES = 4,
  localparam int AW           = $clog2(DEPTH)
) (
  input  logic               clk_clk,
  input  logic               reset_reset,
  input  logic               vec_wr,
  input  logic [AW-1:0]      vec_addr,
  input  logic [NUM_OUT-1:0] vec_stim,
  input  logic [NUM_IN-1:0]  vec_exp,
  input  logic [NUM_IN-1:0]  vec_mask,
  input  logic [AW:0]        num_vec,
  input  logic               start,
  input  logic               abort,
  input  logic               accumulate,
  output logic [NUM_OUT-1:0] chip_stim,
  input  logic [NUM_IN-1:0]  chip_resp,
  output logic               busy,
  output logic               done,
  output logic               pass,
  output logic [15:0]        err_count,
  output logic [NUM_IN-1:0]  pin_fail,
  output logic [AW-1:0]      first_fail,
  output logic               first_fail_vld
);

  localparam logic [AW:0]   DEPTH_W     = (AW+1)'(DEPTH);
  localparam logic [AW:0]   ONE_W       = (AW+1)'(1);
  localparam logic [AW-1:0] IDX_ONE     = AW'(1);
  localparam logic [7:0]    SETTLE_LAST = 8'(SETTLE_CYCLES - 1);

  state_t              state_q, state_d;
  logic [AW-1:0]       idx_q, idx_d;
  logic [AW:0]         num_q, num_d;
  logic [7:0]          cnt_q, cnt_d;
  logic [NUM_OUT-1:0]  stim_q, stim_d;
  logic                pass_q, pass_d;
  logic [15:0]         err_q, err_d;
  logic [NUM_IN-1:0]   pf_q, pf_d;
  logic [AW-1:0]       ff_q, ff_d;
  logic                ffv_q, ffv_d;
  logic                runfail_q, runfail_d;
  logic [NUM_IN-1:0]   sync1_q, sync2_q;

  logic [NUM_OUT-1:0]  r_stim;
  logic [NUM_IN-1:0]   r_exp, r_mask, mis;
  logic [AW:0]         num_clamp;
  logic                last_vec;

  chip_vector_ram #(
    .NUM_OUT(NUM_OUT),
    .NUM_IN (NUM_IN),
    .DEPTH  (DEPTH)
  ) u_ram (
    .clk_clk(clk_clk),
    .we     (vec_wr & ~busy),
    .waddr  (vec_addr),
    .wstim  (vec_stim),
    .wexp   (vec_exp),
    .wmask  (vec_mask),
    .raddr  (idx_q),
    .rstim  (r_stim),
    .rexp   (r_exp),
    .rmask  (r_mask)
  );

  assign num_clamp = (num_vec > DEPTH_W) ? DEPTH_W : num_vec;
  assign last_vec  = ({1'b0, idx_q} == (num_q - ONE_W));
  assign mis       = (sync2_q ^ r_exp) & r_mask;

  // Two-flop synchronizer on the asynchronous socket response.
  always_ff @(posedge clk_clk or posedge reset_reset) begin
    if (reset_reset) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= chip_resp;
      sync2_q <= sync1_q;
    end
  end

  // State and result registers.
  always_ff @(posedge clk_clk or posedge reset_reset) begin
    if (reset_reset) begin
      state_q   <= ST_IDLE;
      idx_q     <= '0;
      num_q     <= '0;
      cnt_q     <= '0;
      stim_q    <= '0;
      pass_q    <= 1'b0;
      err_q     <= '0;
      pf_q      <= '0;
      ff_q      <= '0;
      ffv_q     <= 1'b0;
      runfail_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      num_q     <= num_d;
      cnt_q     <= cnt_d;
      stim_q    <= stim_d;
      pass_q    <= pass_d;
      err_q     <= err_d;
      pf_q      <= pf_d;
      ff_q      <= ff_d;
      ffv_q     <= ffv_d;
      runfail_q <= runfail_d;
    end
  end

  // Next-state logic; abort pre-empts everything, including a pending
  // sample commit and the transition into DONE.
  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    num_d     = num_q;
    cnt_d     = cnt_q;
    stim_d    = stim_q;
    pass_d    = pass_q;
    err_d     = err_q;
    pf_d      = pf_q;
    ff_d      = ff_q;
    ffv_d     = ffv_q;
    runfail_d = runfail_q;

    if (abort && (state_q != ST_IDLE)) begin
      state_d = ST_IDLE;
      stim_d  = '0;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (start) begin
            idx_d     = '0;
            num_d     = num_clamp;
            runfail_d = 1'b0;
            if (!accumulate) begin
              err_d = '0;
              pf_d  = '0;
              ffv_d = 1'b0;
            end
            if (num_clamp == '0) begin
              state_d = ST_DONE;
              pass_d  = 1'b1;
            end else begin
              state_d = ST_DRIVE;
            end
          end
        end
        ST_DRIVE: begin
          stim_d  = r_stim;
          cnt_d   = '0;
          state_d = ST_SETTLE;
        end
        ST_SETTLE: begin
          cnt_d = cnt_q + 8'd1;
          if (cnt_q == SETTLE_LAST) state_d = ST_SAMPLE;
        end
        ST_SAMPLE: begin
          if (mis != '0) begin
            err_d     = sat_inc16(err_q);
            pf_d      = pf_q | mis;
            runfail_d = 1'b1;
            if (!ffv_q) begin
              ff_d  = idx_q;
              ffv_d = 1'b1;
            end
          end
          if (last_vec) begin
            state_d = ST_DONE;
            pass_d  = !(runfail_q || (mis != '0));
          end else begin
            idx_d   = idx_q + IDX_ONE;
            state_d = ST_DRIVE;
          end
        end
        ST_DONE: state_d = ST_IDLE;
        default: state_d = ST_IDLE;
      endcase
    end
  end

  assign chip_stim      = stim_q;
  assign busy           = (state_q != ST_IDLE);
  assign done           = (state_q == ST_DONE);
  assign pass           = pass_q;
  assign err_count      = err_q;
  assign pin_fail       = pf_q;
  assign first_fail     = ff_q;
  assign first_fail_vld = ffv_q;

endmodule
